// File: rtl/nco_freq_meter.sv
// nco_freq_meter
//   Measures the frequency of ref_in against sys_clk. The result is the NCO
//   tuning word that would produce that frequency:
//   f_ref = tuning_word * f_sys / 2^WIDTH.
//   The number of ref_in rising edges counted over a gate of N = 2^GATE_LOG2
//   sys_clk cycles is scaled by 2^(WIDTH-GATE_LOG2). The gate starts on a
//   ref_in edge, so an integer-period input is measured without phase error.
// Ports
//   sys_clk          system clock (sole clock domain)
//   rst_n            asynchronous active-low reset
//   ref_in           signal to measure, asynchronous to sys_clk
//   start            one-cycle measurement request (ignored while busy)
//   abort            synchronous cancel; has priority over start
//   tuning_word_out  last measured tuning word
//   valid            one-cycle pulse when a new result is loaded
//   busy             high whenever a measurement is armed or running
//   no_signal        last result timed out waiting for the arming edge
module nco_freq_meter #(
  parameter int WIDTH      = 32,
  parameter int GATE_LOG2  = 10,
  parameter int CONTINUOUS = 0
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             ref_in,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] tuning_word_out,
  output logic             valid,
  output logic             busy,
  output logic             no_signal
);

  localparam int SHIFT = WIDTH - GATE_LOG2;
  localparam logic [GATE_LOG2-1:0] WIN_LAST = {GATE_LOG2{1'b1}};
  localparam logic [GATE_LOG2-1:0] CNT_ZERO = {GATE_LOG2{1'b0}};
  localparam logic [GATE_LOG2-1:0] CNT_ONE  = {{(GATE_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t               state_r, state_nxt;
  logic                 ref_meta_r, ref_s_r, ref_d_r;
  logic                 rise_s;
  logic [GATE_LOG2-1:0] win_cnt_r, win_cnt_nxt;
  logic [GATE_LOG2-1:0] edge_cnt_r, edge_cnt_nxt;
  logic [GATE_LOG2:0]   count_s;
  logic [WIDTH-1:0]     result_word_s;
  logic [WIDTH-1:0]     tuning_nxt;
  logic                 valid_nxt;
  logic                 no_signal_nxt;
  state_t               after_result_s;

  assign rise_s = ref_s_r & ~ref_d_r;

  // One extra bit: the terminal-cycle edge may push the count to N/2.
  assign count_s       = {1'b0, edge_cnt_r} + {{GATE_LOG2{1'b0}}, rise_s};
  assign result_word_s = WIDTH'(count_s) << SHIFT;
  assign after_result_s = (CONTINUOUS != 0) ? ARM : IDLE;

  assign busy = (state_r != IDLE);

  // Synchronize ref_in and keep one delayed copy for rising-edge detection.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_meta_r <= 1'b0;
      ref_s_r    <= 1'b0;
      ref_d_r    <= 1'b0;
    end else begin
      ref_meta_r <= ref_in;
      ref_s_r    <= ref_meta_r;
      ref_d_r    <= ref_s_r;
    end
  end

  // Next-state, counter and result logic for the IDLE/ARM/MEASURE sequencer.
  always_comb begin
    state_nxt     = state_r;
    win_cnt_nxt   = win_cnt_r;
    edge_cnt_nxt  = edge_cnt_r;
    valid_nxt     = 1'b0;
    tuning_nxt    = tuning_word_out;
    no_signal_nxt = no_signal;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_nxt    = ARM;
          win_cnt_nxt  = CNT_ZERO;
          edge_cnt_nxt = CNT_ZERO;
        end else begin
          state_nxt = IDLE;
        end
      end
      ARM: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (rise_s) begin
          // The arming edge opens the gate but is not itself counted.
          state_nxt    = MEASURE;
          win_cnt_nxt  = CNT_ZERO;
          edge_cnt_nxt = CNT_ZERO;
        end else if (win_cnt_r == WIN_LAST) begin
          state_nxt     = after_result_s;
          win_cnt_nxt   = CNT_ZERO;
          edge_cnt_nxt  = CNT_ZERO;
          valid_nxt     = 1'b1;
          tuning_nxt    = {WIDTH{1'b0}};
          no_signal_nxt = 1'b1;
        end else begin
          win_cnt_nxt = win_cnt_r + CNT_ONE;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (win_cnt_r == WIN_LAST) begin
          state_nxt     = after_result_s;
          win_cnt_nxt   = CNT_ZERO;
          edge_cnt_nxt  = CNT_ZERO;
          valid_nxt     = 1'b1;
          tuning_nxt    = result_word_s;
          no_signal_nxt = 1'b0;
        end else begin
          // At most N/2 synchronized edges fit in a gate, so no wrap.
          win_cnt_nxt  = win_cnt_r + CNT_ONE;
          edge_cnt_nxt = edge_cnt_r + {{(GATE_LOG2-1){1'b0}}, rise_s};
        end
      end
      default: begin
        state_nxt    = IDLE;
        win_cnt_nxt  = CNT_ZERO;
        edge_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  // State, counters and registered result outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      win_cnt_r       <= CNT_ZERO;
      edge_cnt_r      <= CNT_ZERO;
      valid           <= 1'b0;
      tuning_word_out <= {WIDTH{1'b0}};
      no_signal       <= 1'b0;
    end else begin
      state_r         <= state_nxt;
      win_cnt_r       <= win_cnt_nxt;
      edge_cnt_r      <= edge_cnt_nxt;
      valid           <= valid_nxt;
      tuning_word_out <= tuning_nxt;
      no_signal       <= no_signal_nxt;
    end
  end

endmodule
